// File: rtl/hwpe_stream_fifo_flex_pkg.sv
`default_nettype none
// ============================================================================
// Package : hwpe_stream_fifo_flex_pkg
// Brief   : Types and constants shared by the flexible HWPE-Stream FIFO:
//           mode encodings, the flag bundle and a parameter helper.
// Rev     : 1.0 - initial release
// ============================================================================
package hwpe_stream_fifo_flex_pkg;

   localparam logic HWPE_STREAM_FIFO_MODE_REG  = 1'b0;
   localparam logic HWPE_STREAM_FIFO_MODE_PASS = 1'b1;

   typedef struct packed {
      logic       empty;
      logic       full;
      logic       almost_full;
      logic       almost_empty;
      logic [7:0] occupancy;
   } flags_fifo_flex_t;

   // True when v is a non-zero power of two.
   function automatic logic is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_fifo_flex_if.sv
`default_nettype none
// ============================================================================
// Interface : hwpe_stream_intf_stream
// Brief     : HWPE-Stream valid/ready handshake with data and byte strobes.
//             Upstream holds valid/data/strb stable until ready.
// Rev       : 1.0 - initial release
// ============================================================================
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input  ready);
   modport sink   (input  valid, input  data, input  strb, output ready);
   modport master (output valid, output data, output strb, input  ready);
   modport slave  (input  valid, input  data, input  strb, output ready);
endinterface
`default_nettype wire

// File: rtl/hwpe_stream_fifo_flex_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hwpe_stream_fifo_flex_ctrl
// Brief  : Bookkeeping for the flexible FIFO: read/write pointers, occupancy
//          counter, latched output mode and status flags. Storage and the
//          bypass datapath live in the parent.
// Rev    : 1.0 - initial release
// ============================================================================
module hwpe_stream_fifo_flex_ctrl
   import hwpe_stream_fifo_flex_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AF_LEVEL   = 6,
   parameter int unsigned AE_LEVEL   = 1,
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   input  wire logic             clear_i,
   input  wire logic             mode_i,
   input  wire logic             push_hs_i,
   input  wire logic             pop_hs_i,
   input  wire logic             bypass_i,
   output logic                  wr_en_o,
   output logic [PTR_W-1:0]      wr_ptr_o,
   output logic [PTR_W-1:0]      rd_ptr_o,
   output logic                  eff_mode_o,
   output flags_fifo_flex_t      flags_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             rd_en;
   logic             cnt_zero;

   // A bypassed beat never touches storage, so it neither writes nor reads.
   assign wr_en_o  = push_hs_i & ~bypass_i & ~clear_i;
   assign rd_en    = pop_hs_i  & ~bypass_i & ~clear_i;
   assign cnt_zero = (cnt_q == '0);

   // Mode follows the input while empty and is frozen once data is stored.
   assign eff_mode_o = cnt_zero ? mode_i : mode_q;
   assign wr_ptr_o   = wr_ptr_q;
   assign rd_ptr_o   = rd_ptr_q;

   // Next-state for pointers, counter and latched mode; clear flushes all.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mode_d   = (clear_i || cnt_zero) ? mode_i : mode_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_en_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({wr_en_o, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         mode_q   <= HWPE_STREAM_FIFO_MODE_REG;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
      end
   end

   // Flags derive from the registered count only.
   always_comb begin
      flags_o                         = '0;
      flags_o.empty                   = cnt_zero;
      flags_o.full                    = (cnt_q == DEPTH_C);
      flags_o.almost_full             = (cnt_q >= AF_C);
      flags_o.almost_empty            = (cnt_q <= AE_C);
      flags_o.occupancy[CNT_W-1:0]    = cnt_q;
   end

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module : hwpe_stream_fifo_flex
// Brief  : Single-clock HWPE-Stream FIFO with run-time selectable
//          fall-through or registered output, occupancy and watermarks.
//          Holds the storage array and the zero-latency bypass path.
// Rev    : 1.0 - initial release
// ============================================================================
module hwpe_stream_fifo_flex
   import hwpe_stream_fifo_flex_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AF_LEVEL   = 6,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  wire logic              clk_i,
   input  wire logic              rst_ni,
   input  wire logic              clear_i,
   input  wire logic              mode_i,
   output flags_fifo_flex_t       flags_o,
   hwpe_stream_intf_stream.sink   push_i,
   hwpe_stream_intf_stream.source pop_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

   // Reject illegal configurations at elaboration.
   if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 || FIFO_DEPTH > 128) begin : g_bad_depth
      $error("hwpe_stream_fifo_flex: FIFO_DEPTH must be a power of 2 in 2..128");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $error("hwpe_stream_fifo_flex: AF_LEVEL must be in 1..FIFO_DEPTH");
   end
   if (AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("hwpe_stream_fifo_flex: AE_LEVEL must be in 0..FIFO_DEPTH-1");
   end
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
      $error("hwpe_stream_fifo_flex: DATA_WIDTH must be a non-zero multiple of 8");
   end

   logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
   logic [STRB_WIDTH-1:0] strb_q [FIFO_DEPTH];

   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             eff_mode;
   logic             pass_empty;
   logic             push_ready;
   logic             pop_valid;
   logic             push_hs;
   logic             pop_hs;
   logic             bypass;

   // Ready looks only at the registered count, never at downstream ready.
   assign push_ready = ~flags_o.full & ~clear_i;

   // Fall-through only while nothing is stored, so ordering is preserved.
   assign pass_empty = (eff_mode == HWPE_STREAM_FIFO_MODE_PASS) & flags_o.empty;
   assign pop_valid  = pass_empty ? (push_i.valid & ~clear_i) : (~flags_o.empty & ~clear_i);

   assign push_hs = push_i.valid & push_ready;
   assign pop_hs  = pop_valid & pop_o.ready;
   assign bypass  = pass_empty & pop_hs;

   assign push_i.ready = push_ready;
   assign pop_o.valid  = pop_valid;
   assign pop_o.data   = pass_empty ? push_i.data : data_q[rd_ptr];
   assign pop_o.strb   = pass_empty ? push_i.strb : strb_q[rd_ptr];

   // Storage array; contents are don't-care until written, so not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         data_q[wr_ptr] <= push_i.data;
         strb_q[wr_ptr] <= push_i.strb;
      end
   end

   hwpe_stream_fifo_flex_ctrl #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) i_ctrl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .mode_i     (mode_i),
      .push_hs_i  (push_hs),
      .pop_hs_i   (pop_hs),
      .bypass_i   (bypass),
      .wr_en_o    (wr_en),
      .wr_ptr_o   (wr_ptr),
      .rd_ptr_o   (rd_ptr),
      .eff_mode_o (eff_mode),
      .flags_o    (flags_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module : tb_hwpe_stream_fifo_flex
// Brief  : Directed self-checking bench for hwpe_stream_fifo_flex
//          (DATA_WIDTH=32, FIFO_DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_fifo_flex;
   import hwpe_stream_fifo_flex_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic             mode;
   flags_fifo_flex_t flags;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q [$];

   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

   hwpe_stream_fifo_flex #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (8),
      .AF_LEVEL   (6),
      .AE_LEVEL   (1)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clear_i (clear),
      .mode_i  (mode),
      .flags_o (flags),
      .push_i  (push_if),
      .pop_o   (pop_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [31:0] d);
      push_if.valid = 1'b1;
      push_if.data  = d;
      push_if.strb  = 4'hF;
   endtask

   initial begin
      rst_n         = 1'b1;
      clear         = 1'b0;
      mode          = 1'b0;
      push_if.valid = 1'b0;
      push_if.data  = '0;
      push_if.strb  = '0;
      pop_if.ready  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      // ---- reset state
      chk("rst_empty", 32'(flags.empty), 1);
      chk("rst_full", 32'(flags.full), 0);
      chk("rst_ae", 32'(flags.almost_empty), 1);
      chk("rst_af", 32'(flags.almost_full), 0);
      chk("rst_occ", 32'(flags.occupancy), 0);
      chk("rst_pop_valid", 32'(pop_if.valid), 0);
      chk("rst_push_ready", 32'(push_if.ready), 1);
      tick();
      rst_n = 1'b1;
      tick();

      // ---- 1: registered mode, fill 4 then drain in order
      for (int i = 0; i < 4; i++) begin
         push_beat(32'hA0 + 32'(i));
         #1;
         chk("t1_push_ready", 32'(push_if.ready), 1);
         chk("t1_pop_valid", 32'(pop_if.valid), (i > 0) ? 1 : 0);
         if (i > 0) chk("t1_head", pop_if.data, 32'hA0);
         tick();
      end
      push_if.valid = 1'b0;
      #1;
      chk("t1_occ4", 32'(flags.occupancy), 4);
      chk("t1_af", 32'(flags.almost_full), 0);
      chk("t1_ae", 32'(flags.almost_empty), 0);
      pop_if.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_pop_valid_d", 32'(pop_if.valid), 1);
         chk("t1_pop_data", pop_if.data, 32'hA0 + 32'(i));
         chk("t1_pop_strb", 32'(pop_if.strb), 32'hF);
         tick();
      end
      pop_if.ready = 1'b0;
      #1;
      chk("t1_empty", 32'(flags.empty), 1);
      chk("t1_valid_end", 32'(pop_if.valid), 0);
      tick();

      // ---- 2: passthrough, empty, zero latency
      mode         = 1'b1;
      pop_if.ready = 1'b1;
      push_beat(32'h55);
      #1;
      chk("t2_pop_valid", 32'(pop_if.valid), 1);
      chk("t2_pop_data", pop_if.data, 32'h55);
      chk("t2_push_ready", 32'(push_if.ready), 1);
      chk("t2_occ_same", 32'(flags.occupancy), 0);
      tick();
      push_if.valid = 1'b0;
      #1;
      chk("t2_occ_after", 32'(flags.occupancy), 0);
      chk("t2_empty", 32'(flags.empty), 1);
      chk("t2_valid_idle", 32'(pop_if.valid), 0);
      tick();

      // ---- 3: passthrough with back-pressure, order preserved
      pop_if.ready = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         push_beat(32'(v));
         #1;
         chk("t3_pop_valid", 32'(pop_if.valid), 1);
         chk("t3_head", pop_if.data, 32'h1);
         chk("t3_occ", 32'(flags.occupancy), 32'(v - 1));
         tick();
      end
      pop_if.ready = 1'b1;
      push_beat(32'h4);
      #1;
      chk("t3_no_bypass", pop_if.data, 32'h1);
      chk("t3_occ3", 32'(flags.occupancy), 3);
      chk("t3_push_ready", 32'(push_if.ready), 1);
      tick();
      push_if.valid = 1'b0;
      for (int v = 2; v <= 4; v++) begin
         #1;
         chk("t3_drain_valid", 32'(pop_if.valid), 1);
         chk("t3_drain_data", pop_if.data, 32'(v));
         tick();
      end
      #1;
      chk("t3_empty", 32'(flags.empty), 1);
      chk("t3_occ0", 32'(flags.occupancy), 0);
      pop_if.ready = 1'b0;
      tick();

      // ---- 4: fill to full, watermarks, ready timing, random wrap
      mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         push_beat(32'h10 + 32'(k));
         #1;
         chk("t4_fill_ready", 32'(push_if.ready), 1);
         chk("t4_fill_occ", 32'(flags.occupancy), 32'(k));
         chk("t4_fill_af", 32'(flags.almost_full), (k >= 6) ? 1 : 0);
         chk("t4_fill_ae", 32'(flags.almost_empty), (k <= 1) ? 1 : 0);
         tick();
      end
      push_beat(32'h18);
      #1;
      chk("t4_full", 32'(flags.full), 1);
      chk("t4_full_ready", 32'(push_if.ready), 0);
      chk("t4_full_af", 32'(flags.almost_full), 1);
      chk("t4_full_occ", 32'(flags.occupancy), 8);
      pop_if.ready = 1'b1;
      #1;
      chk("t4_no_rdy_path", 32'(push_if.ready), 0);
      chk("t4_pop_head", pop_if.data, 32'h10);
      tick();
      pop_if.ready = 1'b0;
      #1;
      chk("t4_ready_after_pop", 32'(push_if.ready), 1);
      chk("t4_occ7", 32'(flags.occupancy), 7);
      chk("t4_not_full", 32'(flags.full), 0);
      tick();
      push_if.valid = 1'b0;
      #1;
      chk("t4_refull_occ", 32'(flags.occupancy), 8);
      chk("t4_refull", 32'(flags.full), 1);
      q = {};
      for (int k = 1; k <= 8; k++) q.push_back(32'h10 + 32'(k));
      for (int c = 0; c < 24; c++) begin
         logic        v;
         logic        r;
         logic [31:0] d;
         int          sz;
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         d = $urandom;
         push_if.valid = v;
         push_if.data  = d;
         push_if.strb  = 4'hF;
         pop_if.ready  = r;
         #1;
         sz = q.size();
         chk("t4_rnd_ready", 32'(push_if.ready), (sz < 8) ? 1 : 0);
         chk("t4_rnd_valid", 32'(pop_if.valid), (sz > 0) ? 1 : 0);
         chk("t4_rnd_occ", 32'(flags.occupancy), 32'(sz));
         if (sz > 0) chk("t4_rnd_data", pop_if.data, q[0]);
         if (r && sz > 0) void'(q.pop_front());
         if (v && sz < 8) q.push_back(d);
         tick();
      end
      push_if.valid = 1'b0;
      pop_if.ready  = 1'b1;
      for (int k = 0; k < 10 && q.size() > 0; k++) begin
         #1;
         chk("t4_drain_valid", 32'(pop_if.valid), 1);
         chk("t4_drain_data", pop_if.data, q[0]);
         void'(q.pop_front());
         tick();
      end
      #1;
      chk("t4_drain_empty", 32'(flags.empty), 1);
      pop_if.ready = 1'b0;
      tick();

      // ---- 5: clear with concurrent handshakes and mode toggle
      for (int k = 0; k < 5; k++) begin
         push_beat(32'h30 + 32'(k));
         tick();
      end
      push_if.valid = 1'b0;
      #1;
      chk("t5_occ5", 32'(flags.occupancy), 5);
      clear        = 1'b1;
      mode         = 1'b1;
      pop_if.ready = 1'b1;
      push_beat(32'h99);
      #1;
      chk("t5_clr_ready", 32'(push_if.ready), 0);
      chk("t5_clr_valid", 32'(pop_if.valid), 0);
      tick();
      clear = 1'b0;
      push_beat(32'h77);
      #1;
      chk("t5_occ0", 32'(flags.occupancy), 0);
      chk("t5_empty", 32'(flags.empty), 1);
      chk("t5_pass_valid", 32'(pop_if.valid), 1);
      chk("t5_pass_data", pop_if.data, 32'h77);
      tick();
      push_if.valid = 1'b0;
      #1;
      chk("t5_occ_after", 32'(flags.occupancy), 0);
      pop_if.ready = 1'b0;
      mode         = 1'b0;
      tick();

      // ---- 6: mode change while non-empty, then async reset mid-burst
      for (int k = 0; k < 3; k++) begin
         push_beat(32'h40 + 32'(k));
         tick();
      end
      push_if.valid = 1'b0;
      mode          = 1'b1;
      #1;
      chk("t6_occ3", 32'(flags.occupancy), 3);
      chk("t6_valid", 32'(pop_if.valid), 1);
      chk("t6_head", pop_if.data, 32'h40);
      pop_if.ready = 1'b1;
      push_beat(32'h43);
      #1;
      chk("t6_reg_kept", pop_if.data, 32'h40);
      tick();
      push_if.valid = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         #1;
         chk("t6_drain_valid", 32'(pop_if.valid), 1);
         chk("t6_drain_data", pop_if.data, 32'h40 + 32'(v));
         tick();
      end
      #1;
      chk("t6_empty", 32'(flags.empty), 1);
      pop_if.ready = 1'b0;
      mode         = 1'b0;
      tick();
      push_beat(32'h50);
      tick();
      push_beat(32'h51);
      tick();
      push_beat(32'h52);
      #1;
      chk("t6_occ2", 32'(flags.occupancy), 2);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_empty", 32'(flags.empty), 1);
      chk("t6_rst_full", 32'(flags.full), 0);
      chk("t6_rst_af", 32'(flags.almost_full), 0);
      chk("t6_rst_ae", 32'(flags.almost_empty), 1);
      chk("t6_rst_occ", 32'(flags.occupancy), 0);
      chk("t6_rst_ready", 32'(push_if.ready), 1);
      chk("t6_rst_valid", 32'(pop_if.valid), 0);
      push_if.valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
